// File: rtl/pad_pkg.sv
// ---------------------------------------------------------------------------
// pad_pkg
// Shared definitions for the zero-padding stage of the RTLinf datapath.
//   pad_state_t  : controller state encoding (IDLE=0, RUN=1)
//   pad_flags_t  : the four pad-enable flags, packed as {top,bottom,left,right}
//   is_pad_position() : decides whether the current scan position is a border
//                       that must be filled with an all-zero pixel word
// ---------------------------------------------------------------------------
package pad_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pad_state_t;

    // Bit 3 is top, bit 0 is right, so a plain 4-bit vector {top,bottom,left,right}
    // can be assigned straight into this struct.
    typedef struct packed {
        logic top;
        logic bottom;
        logic left;
        logic right;
    } pad_flags_t;

    // A position is padding when it sits on an enabled border row or column.
    function automatic logic is_pad_position(
        input pad_flags_t flags,
        input logic       first_row,
        input logic       last_row,
        input logic       first_col,
        input logic       last_col
    );
        return (flags.top    && first_row) ||
               (flags.bottom && last_row)  ||
               (flags.left   && first_col) ||
               (flags.right  && last_col);
    endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// ---------------------------------------------------------------------------
// pad_pos_counter
// Row-major scan of the padded output frame: column, then row, then iteration.
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   clear                  synchronous return to position (0,0,0)
//   enable                 advance one position
//   num_rows, num_cols     padded frame height/width (must be nonzero when enabled)
//   num_iters              number of frames in the job
//   first_row, last_row    current row is 0 / num_rows-1
//   first_col, last_col    current column is 0 / num_cols-1 (column wrap)
//   last_pos               final position of the final frame
// ---------------------------------------------------------------------------
module pad_pos_counter #(
    parameter int ROW_W  = 11,
    parameter int COL_W  = 11,
    parameter int ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [COL_W-1:0]  num_cols,
    input  logic [ITER_W-1:0] num_iters,
    output logic              first_row,
    output logic              last_row,
    output logic              first_col,
    output logic              last_col,
    output logic              last_pos
);

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ITER_W-1:0] iter;
    logic              last_iter;

    assign first_row = (row == '0);
    assign first_col = (col == '0);
    assign last_row  = (row == num_rows - ROW_W'(1));
    assign last_col  = (col == num_cols - COL_W'(1));
    assign last_iter = (iter == num_iters - ITER_W'(1));
    assign last_pos  = last_iter && last_row && last_col;

    // Nested counter. After the final position everything returns to zero so
    // the block sits at a clean origin while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            iter <= '0;
        end else if (clear) begin
            row  <= '0;
            col  <= '0;
            iter <= '0;
        end else if (enable) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row <= '0;
                    if (last_iter) begin
                        iter <= '0;
                    end else begin
                        iter <= iter + ITER_W'(1);
                    end
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pad.sv
// ---------------------------------------------------------------------------
// pad
// Zero-padding stage between align and the convolution window stage. Each
// word carries NUM_INPUTS channels of one pixel. Optionally inserts one zero
// row/column on each side of every frame.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   configure                        one-cycle pulse loading the job fields
//   num_rows, num_cols, num_iters    unpadded frame size and frame count
//   pad_top/bottom/left/right        per-side pad enables
//   data_in, valid_in, avail_out     upstream handshake (avail_out is ready)
//   data_out, valid_out, avail_in    downstream handshake (avail_in is ready)
// ---------------------------------------------------------------------------
module pad
    import pad_pkg::*;
#(
    parameter int NUM_INPUTS    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int LOG_MAX_ROWS  = 10,
    parameter int LOG_MAX_COLS  = 10,
    parameter int LOG_MAX_ITERS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ROWS-1:0]          num_rows,
    input  logic [LOG_MAX_COLS-1:0]          num_cols,
    input  logic [LOG_MAX_ITERS-1:0]         num_iters,
    input  logic                             pad_top,
    input  logic                             pad_bottom,
    input  logic                             pad_left,
    input  logic                             pad_right,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             avail_in
);

    localparam int WORD_W = NUM_INPUTS * DATA_WIDTH;
    localparam int ROW_W  = LOG_MAX_ROWS + 1;
    localparam int COL_W  = LOG_MAX_COLS + 1;

    pad_state_t               state;
    pad_state_t               next_state;

    logic [LOG_MAX_ROWS-1:0]  cfg_rows;
    logic [LOG_MAX_COLS-1:0]  cfg_cols;
    logic [LOG_MAX_ITERS-1:0] cfg_iters;
    pad_flags_t               cfg_pad;

    logic [ROW_W-1:0]         total_rows;
    logic [COL_W-1:0]         total_cols;

    logic                     first_row;
    logic                     last_row;
    logic                     first_col;
    logic                     last_col;
    logic                     last_pos;

    logic                     pad_position;
    logic                     reg_free;
    logic                     load;
    logic                     cfg_valid;

    // Latch the job description on every configure pulse, whatever the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_rows  <= '0;
            cfg_cols  <= '0;
            cfg_iters <= '0;
            cfg_pad   <= '0;
        end else if (configure) begin
            cfg_rows  <= num_rows;
            cfg_cols  <= num_cols;
            cfg_iters <= num_iters;
            cfg_pad   <= {pad_top, pad_bottom, pad_left, pad_right};
        end
    end

    // Padded geometry is one bit wider so a maximal frame plus two borders fits.
    assign total_rows = ROW_W'(cfg_rows) + ROW_W'(cfg_pad.top) + ROW_W'(cfg_pad.bottom);
    assign total_cols = COL_W'(cfg_cols) + COL_W'(cfg_pad.left) + COL_W'(cfg_pad.right);

    pad_pos_counter #(
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .ITER_W (LOG_MAX_ITERS)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clear     (configure),
        .enable    (load),
        .num_rows  (total_rows),
        .num_cols  (total_cols),
        .num_iters (cfg_iters),
        .first_row (first_row),
        .last_row  (last_row),
        .first_col (first_col),
        .last_col  (last_col),
        .last_pos  (last_pos)
    );

    assign pad_position = is_pad_position(cfg_pad, first_row, last_row, first_col, last_col);

    // The output register can take a new word if it is empty or being drained now.
    assign reg_free  = !valid_out || avail_in;
    assign avail_out = (state == RUN) && !pad_position && reg_free;

    // A configure pulse takes priority, so nothing is loaded in that cycle.
    assign load = (state == RUN) && !configure && reg_free && (pad_position || valid_in);

    assign cfg_valid = (num_rows != '0) && (num_cols != '0) && (num_iters != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Configure restarts (or refuses) the job; otherwise RUN ends as soon as the
    // final word of the final frame has been loaded into the output register.
    always_comb begin
        next_state = state;
        if (configure) begin
            next_state = cfg_valid ? RUN : IDLE;
        end else if ((state == RUN) && load && last_pos) begin
            next_state = IDLE;
        end
    end

    // Output register: pad positions load zeros without consuming input. A
    // configure drops whatever word was pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (configure) begin
            valid_out <= 1'b0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= pad_position ? WORD_W'(0) : data_in;
        end else if (avail_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: doc/pad.md
# pad

Zero-padding stage directly downstream of the align stage in the RTLinf datapath. It takes the aligned pixel stream, where each word holds NUM_INPUTS channels of one pixel, and inserts all-zero pixel words around each frame. Up to one row/column is added on each side. Frame geometry and iteration count are loaded through a configure pulse. Its output feeds the convolution window stage.

## Interface
Parameters:
- NUM_INPUTS, 8, channels per word
- DATA_WIDTH, 8, bits per channel
- LOG_MAX_ROWS, 10, width of row count
- LOG_MAX_COLS, 10, width of column count
- LOG_MAX_ITERS, 16, width of iteration count

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- configure  in  1  one-cycle pulse that loads the fields below
- num_rows  in  LOG_MAX_ROWS  unpadded rows per frame
- num_cols  in  LOG_MAX_COLS  unpadded columns per frame
- num_iters  in  LOG_MAX_ITERS  frames to process
- pad_top, pad_bottom, pad_left, pad_right  in  1 each  add one zero row/column on that side
- data_in  in  NUM_INPUTS*DATA_WIDTH  input pixel word
- valid_in  in  1  data_in valid
- avail_out  out  1  block accepts data_in this cycle
- data_out  out  NUM_INPUTS*DATA_WIDTH  output pixel word
- valid_out  out  1  data_out valid
- avail_in  in  1  downstream accepts data_out this cycle

## Operation
- Transfer rules:
  - Input transfer: valid_in && avail_out.
  - Output transfer: valid_out && avail_in.
- States:
  - IDLE → RUN on configure, if num_rows, num_cols and num_iters are all nonzero; otherwise stay in IDLE.
  - RUN → IDLE after the last output word of the last frame is loaded into the output register.
- Configure sampling: configure in any state latches all config fields, clears the counters and clears valid_out. A configure during RUN aborts the current job, discarding the pending output word, and restarts.
- Output geometry:
  - R = num_rows + pad_top + pad_bottom; counter width LOG_MAX_ROWS+1.
  - C = num_cols + pad_left + pad_right; counter width LOG_MAX_COLS+1.
- Position counters: row r, column c, iteration i, scanned row-major. c wraps at C-1 and increments r; r wraps at R-1 and increments i.
- Pad position: true when (pad_top && r==0) || (pad_bottom && r==R-1) || (pad_left && c==0) || (pad_right && c==C-1).
- Output register load: allowed when the output register is free (!valid_out || avail_in).
  - Pad position: the register loads all zeros; no input is consumed.
  - Data position: the register loads data_in only when valid_in is high; otherwise nothing happens.
- avail_out = (state==RUN) && !pad_position && (!valid_out || avail_in). This is combinational from avail_in.
- Ordering: each frame consumes exactly num_rows*num_cols input words and emits exactly R*C output words. Order is preserved. Input values pass unchanged.

## Timing
- Reset values: state IDLE, valid_out 0, data_out 0, avail_out 0, all counters 0, config registers 0.
- Latency: an input accepted in cycle t appears on data_out in cycle t+1. A pad word decided in cycle t also appears in cycle t+1.
- Throughput: one word per cycle with continuous valid_in and avail_in.
- Stalls: while valid_out && !avail_in, data_out and valid_out hold stable and avail_out=0.
- Job end: valid_out drops the cycle after the final word is taken, unless a new configure has restarted the block.
- Extra input: valid_in arriving in IDLE is ignored (avail_out=0).

## Structure
- Shared RTLinf defines header holds the state encodings (IDLE=0, RUN=1) and the pad-flag bit order {top,bottom,left,right}.
- Sub-module pad_pos_counter: nested col/row/iter counter with a wrap and last flag, clear and enable inputs.

## Test plan
Bench configuration: NUM_INPUTS=4, DATA_WIDTH=8, avail_in=1 unless stated.
- rows=2, cols=2, all pads, iters=1, inputs 1..4 → 16 outputs. Indices 5, 6, 9, 10 carry 1, 2, 3, 4; all others are 0. Block returns to IDLE.
- No pads, rows=3, cols=3, iters=2, inputs 1..18 → 18 outputs identical to the inputs; latency exactly 1 cycle.
- All pads, rows=2, cols=2, avail_in toggling 1/0 → same 16-word sequence. data_out stays stable during every stall cycle; no duplicates, no drops.
- num_iters=0 → avail_out and valid_out stay 0 for 50 cycles.
- rst asserted after 5 outputs → valid_out and avail_out are 0 immediately. Reconfiguring rows=2, cols=2, all pads gives the full 16-word frame from index 0.
- configure during RUN (pad_left only, rows=1, cols=2) → pending word dropped. Next outputs are 0, d0, d1.
